// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per clock, LSB digit first.
// Optional subtract mode is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave io
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic [DIGIT-1:0] s_dig;
  logic             s_co;
  logic             busy;
  logic             done;

  // A new operation is taken whenever the unit is not mid-run.
  assign accept = io.start && (state_q != RUN);
  assign last   = (state_q == RUN) && (cnt_q == LAST);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract is a + ~b + 1; the forced carry replaces cin.
  assign b_ld = io.sub ? ~io.b : io.b;
  assign c_ld = io.sub | io.cin;
`else
  assign b_ld = io.b;
  assign c_ld = io.cin;
`endif

  // DIGIT-bit ripple-carry slice over the low digit of the operands.
  always_comb begin
    logic [DIGIT:0] rc;
    rc    = '0;
    s_dig = '0;
    rc[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      s_dig[i] = a_sh_q[i] ^ b_sh_q[i] ^ rc[i];
      rc[i+1]  = (a_sh_q[i] & b_sh_q[i]) |
                 (rc[i] & (a_sh_q[i] ^ b_sh_q[i]));
    end
    s_co = rc[DIGIT];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        state_d = accept ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next values: load on accept, shift one digit per RUN cycle.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_d     = r_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_sh_d  = io.a;
      b_sh_d  = b_ld;
      r_d     = '0;
      carry_d = c_ld;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> DIGIT;
      b_sh_d  = b_sh_q >> DIGIT;
      r_d     = r_q >> DIGIT;
      r_d[WIDTH-1 -: DIGIT] = s_dig;
      carry_d = s_co;
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        sum_d  = r_d;
        cout_d = s_co;
      end
    end
  end

  // Datapath registers; reset clears everything so an abort leaves no result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.busy = busy;
  assign io.done = done;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder (16/4, 8/8, 8/1).
// Subtract cases run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(16)) io16 ();
  serial_adder_if #(.WIDTH(8))  io88 ();
  serial_adder_if #(.WIDTH(8))  io81 ();

  serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .io(io16.slave));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u88 (
    .clk(clk), .rst(rst), .io(io88.slave));
  serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (
    .clk(clk), .rst(rst), .io(io81.slave));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {cout, sum} of a w-bit add or subtract.
  function automatic logic [32:0] model(input int w,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic c,
                                        input logic s);
    logic [32:0] mask, aa, bb, full;
    mask = (33'd1 << w) - 33'd1;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, b} & mask;
    if (s) begin
      full = (aa - bb) & mask;
      if (aa >= bb) full = full | (33'd1 << w);
    end else begin
      full = aa + bb + {32'd0, c};
    end
    return full;
  endfunction

  task automatic drive16(input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic c,
                         input logic s);
    io16.start = st;
    io16.a     = a;
    io16.b     = b;
    io16.cin   = c;
`ifdef SERIAL_ADDER_SUB_EN
    io16.sub   = s;
`else
    if (s) $display("note: sub ignored in add-only build");
`endif
  endtask

  // One operation on the 16/4 unit; optional ignored start mid-run.
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s_in,
                       input bit poke);
    logic [32:0] m;
    logic s;
    s = s_in & SUB_EN;
    m = model(16, {16'd0, a}, {16'd0, b}, c, s);
    drive16(1'b1, a, b, c, s);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("busy16_run", io16.busy, 1);
      check("done16_run", io16.done, 0);
      if (poke && i == 1) drive16(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
      else drive16(1'b0, 16'($urandom), 16'($urandom),
                   1'($urandom), 1'($urandom) & SUB_EN);
      @(negedge clk);
    end
    check("done16", io16.done, 1);
    check("busy16_done", io16.busy, 0);
    check("sum16", io16.sum, {16'd0, m[15:0]});
    check("cout16", io16.cout, {31'd0, m[16]});
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("done16_pulse", io16.done, 0);
    check("sum16_hold", io16.sum, {16'd0, m[15:0]});
  endtask

  // start held high; every done cycle accepts the next operand pair.
  task automatic b2b(input int cnt);
    logic [15:0] ca, cb;
    logic        cc;
    logic [32:0] m;
    ca = 16'($urandom);
    cb = 16'($urandom);
    cc = 1'($urandom);
    drive16(1'b1, ca, cb, cc, 1'b0);
    @(negedge clk);
    for (int j = 0; j < cnt; j++) begin
      m = model(16, {16'd0, ca}, {16'd0, cb}, cc, 1'b0);
      for (int i = 0; i < 4; i++) begin
        check("b2b_busy", io16.busy, 1);
        check("b2b_done_run", io16.done, 0);
        drive16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        @(negedge clk);
      end
      check("b2b_done", io16.done, 1);
      check("b2b_sum", io16.sum, {16'd0, m[15:0]});
      check("b2b_cout", io16.cout, {31'd0, m[16]});
      ca = 16'($urandom);
      cb = 16'($urandom);
      cc = 1'($urandom);
      if (j < cnt - 1) drive16(1'b1, ca, cb, cc, 1'b0);
      else drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      @(negedge clk);
    end
    check("b2b_end_done", io16.done, 0);
    check("b2b_end_busy", io16.busy, 0);
  endtask

  // Same operands into the 8/8 (N=1) and 8/1 (N=8) units at once.
  task automatic run_small(input logic [7:0] a, input logic [7:0] b,
                           input logic c);
    logic [32:0] m;
    m = model(8, {24'd0, a}, {24'd0, b}, c, 1'b0);
    io88.start = 1'b1; io88.a = a; io88.b = b; io88.cin = c;
    io81.start = 1'b1; io81.a = a; io81.b = b; io81.cin = c;
    @(negedge clk);
    io88.start = 1'b0; io88.a = 8'($urandom); io88.b = 8'($urandom);
    io81.start = 1'b0; io81.a = 8'($urandom); io81.b = 8'($urandom);
    check("busy88", io88.busy, 1);
    check("busy81", io81.busy, 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("done88", io88.done, (k == 1) ? 1 : 0);
      check("done81", io81.done, (k == 8) ? 1 : 0);
      check("busy81_k", io81.busy, (k < 8) ? 1 : 0);
      if (k == 1) begin
        check("sum88", io88.sum, {24'd0, m[7:0]});
        check("cout88", io88.cout, {31'd0, m[8]});
      end
      if (k == 8) begin
        check("sum81", io81.sum, {24'd0, m[7:0]});
        check("cout81", io81.cout, {31'd0, m[8]});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    io88.start = 1'b0; io88.a = '0; io88.b = '0; io88.cin = 1'b0;
    io81.start = 1'b0; io81.a = '0; io81.b = '0; io81.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    io88.sub = 1'b0;
    io81.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", io16.busy, 0);
    check("rst_done", io16.done, 0);
    check("rst_sum", io16.sum, 0);
    check("rst_cout", io16.cout, 0);
    check("rst_sum88", io88.sum, 0);
    check("rst_done81", io81.done, 0);
    rst = 1'b0;
    @(negedge clk);

    run16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    check("sum_5555", io16.sum, 32'h5555);
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("carry_chain_cout", io16.cout, 1);
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    check("all_ones_sum", io16.sum, 32'hFFFF);
    run16(16'h0F0F, 16'h7070, 1'b1, 1'b0, 1'b1);

    b2b(4);

    // Abort the second operation in its second RUN cycle.
    run16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    drive16(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", io16.busy, 0);
    check("abort_done", io16.done, 0);
    check("abort_sum", io16.sum, 0);
    check("abort_cout", io16.cout, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      check("abort_no_done", io16.done, 0);
    end
    check("abort_sum_kept", io16.sum, 0);
    run16(16'hABCD, 16'h1357, 1'b1, 1'b0, 1'b0);

    run_small(8'h80, 8'h80, 1'b0);
    run_small(8'h0F, 8'h01, 1'b0);
    check("sum81_0x10", io81.sum, 32'h10);
    for (int t = 0; t < 4; t++)
      run_small(8'($urandom), 8'($urandom), 1'($urandom));

    for (int t = 0; t < 20; t++)
      run16(16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom), bit'($urandom_range(0, 1)));

`ifdef SERIAL_ADDER_SUB_EN
    run16(16'd5, 16'd7, 1'b0, 1'b1, 1'b0);
    check("sub_5_7_sum", io16.sum, 32'hFFFE);
    check("sub_5_7_cout", io16.cout, 0);
    run16(16'd7, 16'd5, 1'b0, 1'b1, 1'b0);
    check("sub_7_5_sum", io16.sum, 32'h2);
    check("sub_7_5_cout", io16.cout, 1);
    run16(16'd7, 16'd5, 1'b1, 1'b1, 1'b0);
    check("sub_cin_sum", io16.sum, 32'h2);
    check("sub_cin_cout", io16.cout, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
